// File: rtl/ca_msg_gen_bank.sv
// rtl/ca_msg_gen_bank.sv - multi-channel spreading-code / navigation-message generator bank
// Per channel: delayed code chip, message bit, their XOR and a code-epoch pulse, all registered.
module ca_msg_gen_bank #(
   parameter int N_CH          = 8,
   parameter int WORD_W        = 32,
   parameter int CODE_LEN      = 1023,
   parameter int MSG_BITS      = 1500,
   parameter int CODES_PER_BIT = 1,
   parameter int CAW           = $clog2(CODE_LEN),
   // one spare channel-select bit so out-of-range targets can be flagged
   parameter int CHW           = $clog2(N_CH + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_valid,
   input  logic [CHW-1:0]      wr_ch,
   input  logic                wr_type,
   input  logic                wr_first,
   input  logic [WORD_W-1:0]   wr_data,
   output logic                wr_err,
   input  logic [N_CH-1:0]     ch_en,
   input  logic [N_CH-1:0]     chip_en,
   input  logic [N_CH*CAW-1:0] delay_in,
   input  logic [N_CH-1:0]     delay_ld,
   output logic [N_CH-1:0]     code_out,
   output logic [N_CH-1:0]     msg_out,
   output logic [N_CH-1:0]     chip_out,
   output logic [N_CH-1:0]     epoch
);
   localparam int CODE_WORDS = (CODE_LEN + WORD_W - 1) / WORD_W;
   localparam int MSG_WORDS  = (MSG_BITS + WORD_W - 1) / WORD_W;
   localparam int WB         = $clog2(WORD_W);
   localparam int CWA        = $clog2(CODE_WORDS);
   localparam int MWA        = $clog2(MSG_WORDS);
   localparam int MBW        = $clog2(MSG_BITS);
   localparam int RPW        = (CODES_PER_BIT > 1) ? $clog2(CODES_PER_BIT) : 1;
   localparam int CHI        = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic [WORD_W-1:0] code_ram [N_CH][CODE_WORDS];
   logic [WORD_W-1:0] msg_ram  [N_CH][MSG_WORDS];

   logic [CWA-1:0] code_addr;
   logic [CWA-1:0] code_waddr;
   logic [MWA-1:0] msg_addr;
   logic [MWA-1:0] msg_waddr;
   logic           wr_ok;

   logic [CAW-1:0] chip_cnt [N_CH];
   logic [CAW-1:0] chip_nx  [N_CH];
   logic [CAW-1:0] dly      [N_CH];
   logic [CAW-1:0] dly_nx   [N_CH];
   logic [CAW-1:0] pend     [N_CH];
   logic [CAW-1:0] pend_nx  [N_CH];
   logic [RPW-1:0] rep_cnt  [N_CH];
   logic [RPW-1:0] rep_nx   [N_CH];
   logic [MBW-1:0] msg_cnt  [N_CH];
   logic [MBW-1:0] msg_nx   [N_CH];
   logic [N_CH-1:0] code_nx;
   logic [N_CH-1:0] msg_bit_nx;
   logic [N_CH-1:0] epoch_nx;

   function automatic logic [CAW-1:0] rd_index(input logic [CAW-1:0] cnt, input logic [CAW-1:0] d);
      logic [CAW:0] r;
      r = {1'b0, cnt} - {1'b0, d} + ((cnt < d) ? (CAW+1)'(CODE_LEN) : '0);
      return r[CAW-1:0];
   endfunction

   function automatic logic [CAW-1:0] clamp_delay(input logic [CAW-1:0] d);
      return (d >= CAW'(CODE_LEN)) ? CAW'(CODE_LEN - 1) : d;
   endfunction

   assign wr_ok      = wr_valid && (wr_ch < CHW'(N_CH));
   assign code_waddr = wr_first ? '0 : code_addr;
   assign msg_waddr  = wr_first ? '0 : msg_addr;

   // Storage is not reset; a write presented while rst is high is dropped.
   always_ff @(posedge clk) begin
      if (wr_ok && !rst) begin
         if (wr_type)
            msg_ram[wr_ch[CHI-1:0]][msg_waddr] <= wr_data;
         else
            code_ram[wr_ch[CHI-1:0]][code_waddr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         code_addr <= '0;
         msg_addr  <= '0;
         wr_err    <= 1'b0;
      end else if (wr_valid) begin
         if (!wr_ok)
            wr_err <= 1'b1;
         else if (wr_type)
            msg_addr <= (msg_waddr == MWA'(MSG_WORDS - 1)) ? '0 : msg_waddr + MWA'(1);
         else
            code_addr <= (code_waddr == CWA'(CODE_WORDS - 1)) ? '0 : code_waddr + CWA'(1);
      end
   end

   always_comb begin
      logic           step;
      logic           apply;
      logic [CAW-1:0] cur_rd;
      logic [CAW-1:0] new_rd;
      step       = 1'b0;
      apply      = 1'b0;
      cur_rd     = '0;
      new_rd     = '0;
      code_nx    = '0;
      msg_bit_nx = '0;
      epoch_nx   = '0;
      for (int c = 0; c < N_CH; c++) begin
         step       = ch_en[c] & chip_en[c];
         pend_nx[c] = delay_ld[c] ? clamp_delay(delay_in[c*CAW +: CAW]) : pend[c];
         apply      = !ch_en[c] || (step && (chip_cnt[c] == CAW'(CODE_LEN - 1)));
         dly_nx[c]  = apply ? pend_nx[c] : dly[c];
         cur_rd     = rd_index(chip_cnt[c], dly[c]);
         chip_nx[c] = chip_cnt[c];
         rep_nx[c]  = rep_cnt[c];
         msg_nx[c]  = msg_cnt[c];
         if (!ch_en[c]) begin
            chip_nx[c] = '0;
            rep_nx[c]  = '0;
            msg_nx[c]  = '0;
         end else if (step) begin
            chip_nx[c] = (chip_cnt[c] == CAW'(CODE_LEN - 1)) ? '0 : chip_cnt[c] + CAW'(1);
            // message timing follows the delayed code's period boundary, not chip_cnt's
            if (cur_rd == CAW'(CODE_LEN - 1)) begin
               if (rep_cnt[c] == RPW'(CODES_PER_BIT - 1)) begin
                  rep_nx[c] = '0;
                  msg_nx[c] = (msg_cnt[c] == MBW'(MSG_BITS - 1)) ? '0 : msg_cnt[c] + MBW'(1);
               end else begin
                  rep_nx[c] = rep_cnt[c] + RPW'(1);
               end
            end
         end
         new_rd        = rd_index(chip_nx[c], dly_nx[c]);
         code_nx[c]    = ch_en[c] & code_ram[c][new_rd[WB +: CWA]][~new_rd[WB-1:0]];
         msg_bit_nx[c] = ch_en[c] & msg_ram[c][msg_nx[c][WB +: MWA]][~msg_nx[c][WB-1:0]];
         epoch_nx[c]   = step && (new_rd == '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < N_CH; c++) begin
            chip_cnt[c] <= '0;
            dly[c]      <= '0;
            pend[c]     <= '0;
            rep_cnt[c]  <= '0;
            msg_cnt[c]  <= '0;
         end
         code_out <= '0;
         msg_out  <= '0;
         chip_out <= '0;
         epoch    <= '0;
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            chip_cnt[c] <= chip_nx[c];
            dly[c]      <= dly_nx[c];
            pend[c]     <= pend_nx[c];
            rep_cnt[c]  <= rep_nx[c];
            msg_cnt[c]  <= msg_nx[c];
         end
         code_out <= code_nx;
         msg_out  <= msg_bit_nx;
         chip_out <= code_nx ^ msg_bit_nx;
         epoch    <= epoch_nx;
      end
   end
endmodule

// File: tb/tb_ca_msg_gen_bank.sv
// tb/tb_ca_msg_gen_bank.sv - randomized bench for ca_msg_gen_bank
// Reference model indexes code and message by chip/bit number and uses modular integer arithmetic.
module tb_ca_msg_gen_bank;
   localparam int N_CH = 8;
   localparam int CL   = 1023;
   localparam int MB   = 1500;
   localparam int CPB  = 1;
   localparam int CAW  = 10;

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_valid;
   logic [3:0]        wr_ch;
   logic              wr_type;
   logic              wr_first;
   logic [31:0]       wr_data;
   logic              wr_err;
   logic [N_CH-1:0]   ch_en;
   logic [N_CH-1:0]   chip_en;
   logic [N_CH*CAW-1:0] delay_in;
   logic [N_CH-1:0]   delay_ld;
   logic [N_CH-1:0]   code_out;
   logic [N_CH-1:0]   msg_out;
   logic [N_CH-1:0]   chip_out;
   logic [N_CH-1:0]   epoch;

   ca_msg_gen_bank dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ch(wr_ch), .wr_type(wr_type),
      .wr_first(wr_first), .wr_data(wr_data), .wr_err(wr_err), .ch_en(ch_en),
      .chip_en(chip_en), .delay_in(delay_in), .delay_ld(delay_ld), .code_out(code_out),
      .msg_out(msg_out), .chip_out(chip_out), .epoch(epoch)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   bit cmem [N_CH][1024];
   bit mmem [N_CH][1536];
   int m_cnt [N_CH];
   int m_rep [N_CH];
   int m_msg [N_CH];
   int m_dly [N_CH];
   int m_pend[N_CH];
   int m_caddr = 0;
   int m_maddr = 0;
   bit m_err   = 1'b0;
   logic [N_CH-1:0] e_code  = '0;
   logic [N_CH-1:0] e_msg   = '0;
   logic [N_CH-1:0] e_chip  = '0;
   logic [N_CH-1:0] e_epoch = '0;

   task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
      end
   endtask

   task automatic bchk(input string nm, input logic act, input logic exp);
      cmp(nm, {7'b0, act}, {7'b0, exp});
   endtask

   task automatic model_step();
      for (int c = 0; c < N_CH; c++) begin
         bit en;
         bit st;
         bit at_end;
         int din;
         int pn;
         int old_rd;
         int rd;
         en     = ch_en[c];
         st     = en && chip_en[c];
         din    = int'(delay_in[c*CAW +: CAW]);
         if (din > CL - 1) din = CL - 1;
         pn     = delay_ld[c] ? din : m_pend[c];
         old_rd = (m_cnt[c] - m_dly[c] + CL) % CL;
         at_end = (m_cnt[c] == CL - 1);
         if (!en) begin
            m_cnt[c] = 0;
            m_rep[c] = 0;
            m_msg[c] = 0;
         end else if (st) begin
            m_cnt[c] = (m_cnt[c] + 1) % CL;
            if (old_rd == CL - 1) begin
               m_rep[c]++;
               if (m_rep[c] == CPB) begin
                  m_rep[c] = 0;
                  m_msg[c] = (m_msg[c] + 1) % MB;
               end
            end
         end
         if (!en || (st && at_end)) m_dly[c] = pn;
         m_pend[c]  = pn;
         rd         = (m_cnt[c] - m_dly[c] + CL) % CL;
         e_code[c]  = en && cmem[c][rd];
         e_msg[c]   = en && mmem[c][m_msg[c]];
         e_chip[c]  = e_code[c] ^ e_msg[c];
         e_epoch[c] = st && (rd == 0);
      end
      // memory update after output evaluation: a same-cycle write is not seen yet
      if (wr_valid) begin
         if (wr_ch >= 4'(N_CH)) begin
            m_err = 1'b1;
         end else begin
            int ch;
            int a;
            ch = int'(wr_ch);
            if (wr_type) begin
               a = wr_first ? 0 : m_maddr;
               for (int i = 0; i < 32; i++) mmem[ch][a*32+i] = wr_data[31-i];
               m_maddr = (a + 1) % 47;
            end else begin
               a = wr_first ? 0 : m_caddr;
               for (int i = 0; i < 32; i++) cmem[ch][a*32+i] = wr_data[31-i];
               m_caddr = (a + 1) % 32;
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         for (int c = 0; c < N_CH; c++) begin
            m_cnt[c] = 0; m_rep[c] = 0; m_msg[c] = 0; m_dly[c] = 0; m_pend[c] = 0;
         end
         m_caddr = 0; m_maddr = 0; m_err = 1'b0;
         e_code = '0; e_msg = '0; e_chip = '0; e_epoch = '0;
      end else begin
         model_step();
      end
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         cmp("code_out", code_out, e_code);
         cmp("msg_out", msg_out, e_msg);
         cmp("chip_out", chip_out, e_chip);
         cmp("epoch", epoch, e_epoch);
         bchk("wr_err", wr_err, m_err);
      end
   end

   task automatic wr(input int ch, input bit typ, input bit first, input logic [31:0] d);
      wr_valid = 1'b1;
      wr_ch    = 4'(ch);
      wr_type  = typ;
      wr_first = first;
      wr_data  = d;
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] d;
      rst = 1'b1;
      wr_valid = 1'b0; wr_ch = '0; wr_type = 1'b0; wr_first = 1'b0; wr_data = '0;
      ch_en = '0; chip_en = '0; delay_in = '0; delay_ld = '0;
      repeat (3) @(negedge clk);
      cmp("reset_code", code_out, 8'h00);
      cmp("reset_epoch", epoch, 8'h00);
      bchk("reset_wr_err", wr_err, 1'b0);
      rst    = 1'b0;
      chk_en = 1'b1;

      // fill every channel; ch0 gets alternating chips, ch1 wraps its message address
      for (int c = 0; c < N_CH; c++) begin
         for (int w = 0; w < 32; w++) begin
            if (c == 2 && w == 31) begin
               wr(8, 1'b0, 1'b0, $urandom);
               bchk("wr_err_set", wr_err, 1'b1);
            end
            wr(c, 1'b0, w == 0, (c == 0) ? 32'hAAAA_AAAA : $urandom);
         end
         for (int w = 0; w < ((c == 1) ? 48 : 47); w++) begin
            if (c == 0)      d = (w == 0) ? 32'h8000_0000 : 32'h0;
            else if (c == 1) d = (w == 0) ? 32'h0 : (w == 47) ? 32'hFFFF_FFFF : $urandom;
            else             d = $urandom;
            wr(c, 1'b1, w == 0, d);
         end
      end
      wr_valid = 1'b0;
      ch_en    = '1;
      @(negedge clk);

      for (int k = 0; k <= 2100; k++) begin
         if (k == 0) begin
            bchk("k0_code0", code_out[0], 1'b1);
            bchk("k0_msg1_wrap", msg_out[1], 1'b1);
            cmp("k0_epoch", epoch, 8'h00);
         end
         if (k == 1) bchk("k1_code0", code_out[0], 1'b0);
         if (k == 501) begin
            bchk("ch2_off_code", code_out[2], 1'b0);
            bchk("ch2_off_msg", msg_out[2], 1'b0);
         end
         if (k == 1022) begin
            bchk("k1022_code0", code_out[0], 1'b1);
            bchk("k1022_msg0", msg_out[0], 1'b1);
            bchk("k1022_chip0", chip_out[0], 1'b0);
            bchk("k1022_epoch0", epoch[0], 1'b0);
         end
         if (k == 1023) begin
            bchk("k1023_epoch0", epoch[0], 1'b1);
            bchk("k1023_msg0", msg_out[0], 1'b0);
            bchk("k1023_chip0", chip_out[0], 1'b1);
            bchk("k1023_epoch3", epoch[3], 1'b0);
         end
         if (k == 1028) bchk("k1028_epoch3", epoch[3], 1'b1);
         if (k == 2046) bchk("k2046_epoch0", epoch[0], 1'b1);

         chip_en  = 8'($urandom) | 8'h09;
         ch_en[2] = !(k >= 500 && k < 510);
         if (k == 510) chip_en[2] = 1'b0;
         for (int c = 0; c < N_CH; c++) begin
            delay_in[c*CAW +: CAW] = 10'($urandom_range(0, 1023));
            delay_ld[c] = (c != 0 && c != 3) && ($urandom_range(0, 15) == 0);
         end
         delay_ld[3] = (k == 100);
         if (k == 100) delay_in[3*CAW +: CAW] = 10'd5;
         wr_valid = 1'b0;
         if ($urandom_range(0, 7) == 0) begin
            wr_valid = 1'b1;
            wr_ch    = 4'($urandom_range(4, 7));
         end else if ($urandom_range(0, 63) == 0) begin
            wr_valid = 1'b1;
            wr_ch    = 4'($urandom_range(8, 15));
         end
         wr_type  = 1'($urandom_range(0, 1));
         wr_first = ($urandom_range(0, 7) == 0);
         wr_data  = $urandom;
         @(negedge clk);
      end

      // asynchronous reset in the middle of a chip step
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      cmp("arst_code", code_out, 8'h00);
      cmp("arst_msg", msg_out, 8'h00);
      cmp("arst_chip", chip_out, 8'h00);
      cmp("arst_epoch", epoch, 8'h00);
      bchk("arst_wr_err", wr_err, 1'b0);
      @(negedge clk);
      wr_valid = 1'b1; wr_ch = 4'd9; ch_en = '0; chip_en = '0; delay_ld = '0;
      @(negedge clk);
      rst = 1'b0;
      wr_valid = 1'b0;
      repeat (20) @(negedge clk);
      bchk("post_rst_wr_err", wr_err, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
